lfsr_sequencer: RTL and testbench

LFSR_SEQUENCER -- requirements
Module: lfsr_sequencer

---
 rtl/lfsr_seq_pkg.sv | 27 ++
 rtl/lfsr_seq_core.sv | 38 +++
 rtl/lfsr_sequencer.sv | 144 ++++++++++++++
 tb/tb_lfsr_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared definitions for the LFSR sequencer: default widths, FSM state encodings
// and the feedback tap positions of the Galois LFSR.
package lfsr_seq_pkg;

    localparam int unsigned LFSR_N_DEFAULT = 26;
    localparam int unsigned SEED_W_DEFAULT = 4;

    localparam int NUM_TAPS = 3;
    localparam int TAP_IDX [NUM_TAPS] = '{1, 2, 6};

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t GEN  = 2'd2;
    localparam state_t HOLD = 2'd3;

    function automatic logic is_tap(input int idx);
        logic hit;
        hit = 1'b0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if (TAP_IDX[t] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lfsr_seq_core.sv
// Galois LFSR register with a synchronous load of a zero-extended seed and a step enable.
module lfsr_seq_core
    import lfsr_seq_pkg::*;
#(
    parameter int unsigned N      = LFSR_N_DEFAULT,
    parameter int unsigned SEED_W = SEED_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [SEED_W-1:0] seed,
    output logic [N-1:0]      q
);

    logic [N-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = N'(seed);
        end else if (step) begin
            // Shift up by one; the outgoing MSB folds back into bit 0 and the tap positions.
            lfsr_d[0] = lfsr_q[N-1];
            for (int i = 1; i < int'(N); i++) begin
                lfsr_d[i] = lfsr_q[i-1] ^ (is_tap(i) & lfsr_q[N-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= '0;
        else        lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_sequencer.sv
// Sequencer that loads a seed, runs the LFSR N steps per word and hands words out with
// valid/ready. Optional seed==0 rejection is enabled by LFSR_SEQ_ZERO_DETECT_EN.
module lfsr_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int unsigned N      = LFSR_N_DEFAULT,
    parameter int unsigned SEED_W = SEED_W_DEFAULT,
    parameter int unsigned BLK_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic              stop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic              busy,
    output logic [BLK_W-1:0]  blocks
`ifdef LFSR_SEQ_ZERO_DETECT_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic              stop_pending_q, stop_pending_d;
    logic              out_valid_q, out_valid_d;
    logic [BLK_W-1:0]  blocks_q, blocks_d;
    logic              load, step, accept, handshake;
`ifdef LFSR_SEQ_ZERO_DETECT_EN
    logic              err_q, err_d;
`endif

    assign handshake = (state_q == HOLD) && out_valid_q && out_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        seed_d         = seed_q;
        stop_pending_d = stop_pending_q;
        blocks_d       = blocks_q;
        load           = 1'b0;
        step           = 1'b0;
        accept         = 1'b0;
`ifdef LFSR_SEQ_ZERO_DETECT_EN
        err_d          = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef LFSR_SEQ_ZERO_DETECT_EN
                    if (seed == '0) err_d = 1'b1;
                    else            accept = 1'b1;
`else
                    accept = 1'b1;
`endif
                end
                if (accept) begin
                    seed_d         = seed;
                    stop_pending_d = stop;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = GEN;
                if (stop) stop_pending_d = 1'b1;
            end
            GEN: begin
                step = 1'b1;
                if (stop) stop_pending_d = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) state_d = HOLD;
                else                        cnt_d = cnt_q + 1'b1;
            end
            HOLD: begin
                if (stop) stop_pending_d = 1'b1;
                if (handshake) begin
                    blocks_d = blocks_q + 1'b1;
                    if (stop_pending_q || stop) begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = GEN;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid is registered off HOLD, so it rises one cycle after the last step.
    assign out_valid_d = (state_q == HOLD) && !handshake;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            seed_q         <= '0;
            stop_pending_q <= 1'b0;
            out_valid_q    <= 1'b0;
            blocks_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            seed_q         <= seed_d;
            stop_pending_q <= stop_pending_d;
            out_valid_q    <= out_valid_d;
            blocks_q       <= blocks_d;
        end
    end

`ifdef LFSR_SEQ_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

    lfsr_seq_core #(
        .N      (N),
        .SEED_W (SEED_W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .seed  (seed_q),
        .q     (out_data)
    );

    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign blocks    = blocks_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Directed bench for lfsr_sequencer; word values follow from x^(26k) mod x^26+x^6+x^2+x+1.
module tb_lfsr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  seed;
    logic        stop;
    logic        out_ready;
    logic        out_valid;
    logic [25:0] out_data;
    logic        busy;
    logic [7:0]  blocks;
`ifdef LFSR_SEQ_ZERO_DETECT_EN
    logic        err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .stop      (stop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .blocks    (blocks)
`ifdef LFSR_SEQ_ZERO_DETECT_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int i;
        i = 0;
        while (!out_valid && i < bound) begin
            tick();
            i++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    initial begin
        int hs;
        int cyc;
        int seen;

        reset = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0; seed = 4'h0;
        tick(2);
        check("rst_valid",  32'(out_valid), 0);
        check("rst_busy",   32'(busy),      0);
        check("rst_blocks", 32'(blocks),    0);
        check("rst_data",   32'(out_data),  0);
        reset = 1'b1;

        // Run A: seed 1, exact latency, backpressure, resume into a second word.
        start = 1'b1; seed = 4'h1;
        tick();
        start = 1'b0; seed = 4'h0;
        check("a_busy", 32'(busy), 1);
        tick(27);
        check("a_valid_e27", 32'(out_valid), 0);
        tick();
        check("a_valid_e28", 32'(out_valid), 1);
        check("a_data",      32'(out_data),  32'h0000047);
        check("a_blocks0",   32'(blocks),    0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("a_hold_valid", 32'(out_valid), 1);
            check("a_hold_data",  32'(out_data),  32'h0000047);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_blocks1",    32'(blocks),    1);
        check("a_gen_valid",  32'(out_valid), 0);
        check("a_gen_busy",   32'(busy),      1);
        tick(2);
        check("a_blocks_once", 32'(blocks), 1);
        wait_valid(40, "a_word2_timeout");
        check("a_word2", 32'(out_data), 32'h0001015);
        // Stop coincident with the handshake ends the run on that handshake.
        stop = 1'b1; out_ready = 1'b1;
        tick();
        stop = 1'b0; out_ready = 1'b0;
        check("a_blocks2",   32'(blocks),    2);
        check("a_idle_busy", 32'(busy),      0);
        check("a_idle_vld",  32'(out_valid), 0);
        tick(3);
        check("a_idle_vld2", 32'(out_valid), 0);
        check("a_idle_data", 32'(out_data),  32'h0001015);

        // Run B: stop and a seed=F start pulsed mid-GEN.
        start = 1'b1; seed = 4'h1;
        tick();
        start = 1'b0;
        tick(4);
        start = 1'b1; seed = 4'hF; stop = 1'b1;
        tick();
        start = 1'b0; seed = 4'h0; stop = 1'b0;
        tick(22);
        check("b_valid_e27", 32'(out_valid), 0);
        tick();
        check("b_valid_e28", 32'(out_valid), 1);
        check("b_data",      32'(out_data),  32'h0000047);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b_blocks3", 32'(blocks), 3);
        check("b_busy",    32'(busy),   0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        check("b_quiet", 32'(seen), 0);

        // Run C: asynchronous reset mid-GEN, then restart.
        start = 1'b1; seed = 4'h1;
        tick();
        start = 1'b0;
        tick(10);
        reset = 1'b0;
        #1;
        check("c_rst_valid",  32'(out_valid), 0);
        check("c_rst_blocks", 32'(blocks),    0);
        check("c_rst_busy",   32'(busy),      0);
        check("c_rst_data",   32'(out_data),  0);
        tick();
        reset = 1'b1;
        start = 1'b1; seed = 4'h1;
        tick();
        start = 1'b0; seed = 4'h0;
        tick(28);
        check("c_valid", 32'(out_valid), 1);
        check("c_data",  32'(out_data),  32'h0000047);

        // Blocks wrap after 256 handshakes with out_ready held high.
        out_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (hs < 256 && cyc < 9000) begin
            if (out_valid) begin
                if (hs == 255) check("w_blocks255", 32'(blocks), 255);
                hs++;
            end
            tick();
            cyc++;
        end
        check("w_hs_count", 32'(hs),     256);
        check("w_blocks0",  32'(blocks), 0);
        check("w_busy",     32'(busy),   1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("w_stop_busy",   32'(busy),   0);
        check("w_stop_blocks", 32'(blocks), 1);

        // Seed zero handling.
        start = 1'b1; seed = 4'h0;
        tick();
        start = 1'b0;
`ifdef LFSR_SEQ_ZERO_DETECT_EN
        check("z_err",    32'(err),    1);
        check("z_busy",   32'(busy),   0);
        check("z_blocks", 32'(blocks), 1);
        tick();
        check("z_err_off", 32'(err),  0);
        check("z_busy2",   32'(busy), 0);
`else
        check("z_busy", 32'(busy), 1);
        tick(28);
        check("z_valid", 32'(out_valid), 1);
        check("z_data",  32'(out_data),  0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
